mem_access: RTL and testbench
=============================

// Module: mem_access
// PURPOSE
//  Memory-access stage that sits directly upstream of the load-extraction stage.
//  - Takes the EX-stage result: ALU address/result, store data, load/store info.
//  - Runs one word-aligned data-memory transaction over a req/ack bus.
//    Stores get byte-lane steering; loads capture the raw word.
//  - Hands the captured word, byte offset, load info and ALU result to load
//    extraction through a registered valid/ready handshake.
// PARAMETERS
//  TIMEOUT_CYCLES  255  cycles in BUS without mem_ack before bus_err is flagged (>=1)
// PORTS
//  clk             in   1   single clock, rising edge
//  rst             in   1   asynchronous, active-high reset
//  in_valid        in   1   upstream op valid
//  in_ready        out  1   stage can accept an op
//  alu_result      in   32  effective address, or ALU result for non-memory ops
//  store_data      in   32  rs2 value for stores
//  info_load       in   3   load code (`Lb/`Lh/`Lw/`Lbu/`Lhu); any other code = not a load
//  info_store      in   2   00 none, 01 SB, 10 SH, 11 SW (wins if both set)
//  mem_req         out  1   bus request, held until mem_ack
//  mem_we          out  1   1 = write
//  mem_addr        out  32  {alu_result[31:2],2'b00}
//  mem_wdata       out  32  lane-steered store data
//  mem_be          out  4   byte enables (0000 on reads)
//  mem_ack         in   1   transaction complete; mem_rdata valid this cycle
//  mem_rdata       in   32  read word
//  out_valid       out  1   result valid to load-extraction stage
//  out_ready       in   1   load-extraction stage accepts
//  addr_data       out  32  captured read word (0 if not a load)
//  addr_rem        out  2   alu_result[1:0] of the op
//  info_load_out   out  3   info_load of the op
//  alu_result_out  out  32  alu_result of the op
//  misaligned      out  1   op was misaligned; no bus access made
//  bus_err         out  1   op timed out on the bus
// BEHAVIOUR
//  - Reset: all outputs 0, FSM in IDLE, timeout counter 0. Reset mid-BUS drops
//    mem_req at once. The transaction is abandoned; a later mem_ack in IDLE/RESP
//    is ignored.
//  - FSM states: IDLE, BUS, RESP.
//    - in_ready = (state==IDLE). There is no accept/RESP overlap, so the maximum
//      rate is one op per 2 cycles.
//  - IDLE, accept (in_valid & in_ready): register alu_result, addr_rem,
//    info_load and store fields, then branch:
//    - non-memory op -> RESP (out_valid the next cycle).
//    - misaligned -> RESP with misaligned=1. Misaligned means SW/LW with rem!=0,
//      or SH/LH/LHU with rem==3. Byte ops never misalign.
//    - otherwise -> BUS.
//  - BUS:
//    - mem_req=1; mem_addr, mem_we, mem_be and mem_wdata are stable until ack.
//    - Store lanes: mem_wdata = store_data << (8*rem).
//      - SB: mem_be = 0001<<rem.
//      - SH: mem_be = 0011<<rem.
//      - SW: mem_be = 1111.
//    - Read: mem_we=0, mem_be=0000.
//    - On mem_ack: addr_data <= mem_rdata for loads (0 for stores); mem_req=0 in
//      the same cycle; go to RESP. Earliest: ack in the first BUS cycle, so
//      out_valid is 2 cycles after accept.
//    - Timeout: count cycles in BUS. When the count reaches TIMEOUT_CYCLES with
//      no ack: bus_err=1, addr_data=0, mem_req=0, go to RESP.
//  - RESP:
//    - out_valid=1; all result outputs held stable until out_ready.
//    - out_valid & out_ready -> IDLE next cycle; out_valid, misaligned and
//      bus_err clear.
//  - Widths: addresses are 32-bit with no arithmetic; the shift is truncated
//    to 32 bits.
// TESTING
//  - LW 0x100, ack 1 cycle later with rdata 0xDEADBEEF:
//    -> mem_addr=0x100, be=0000; out_valid with addr_data=0xDEADBEEF, rem=0.
//  - SB at 0x203, store_data 0x000000A5:
//    -> mem_wdata=0xA5000000, be=1000, we=1; out_valid after ack, addr_data=0.
//  - LH at 0x0F7 (rem 3), or SW at 0x102:
//    -> no mem_req; out_valid next cycle, misaligned=1.
//  - TIMEOUT_CYCLES=4, LW with ack never asserted:
//    -> mem_req for 4 cycles, then bus_err=1, out_valid=1.
//  - out_ready low for 3 cycles in RESP:
//    -> outputs stable and in_ready=0 throughout; new in_valid not accepted.
//  - rst pulse mid-BUS, then stray mem_ack:
//    -> mem_req=0 immediately, outputs 0, no out_valid.

Source files
------------

// File: rtl/mem_access.sv
// Memory-access stage: runs one word-aligned req/ack data-memory transaction per op
// and hands the captured word plus op info to load extraction over valid/ready.
module mem_access #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic [2:0]  info_load,
  input  logic [1:0]  info_store,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] addr_data,
  output logic [1:0]  addr_rem,
  output logic [2:0]  info_load_out,
  output logic [31:0] alu_result_out,
  output logic        misaligned,
  output logic        bus_err
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  localparam logic [2:0] LD_B  = 3'b000;
  localparam logic [2:0] LD_H  = 3'b001;
  localparam logic [2:0] LD_W  = 3'b010;
  localparam logic [2:0] LD_BU = 3'b100;
  localparam logic [2:0] LD_HU = 3'b101;

  localparam logic [1:0] ST_NONE = 2'b00;
  localparam logic [1:0] ST_B    = 2'b01;
  localparam logic [1:0] ST_H    = 2'b10;
  localparam logic [1:0] ST_W    = 2'b11;

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_t        state, state_next;
  logic [CW-1:0] cnt;
  logic          load_q;

  logic          is_store, is_load, word_op, half_op, mis;
  logic [1:0]    rem;
  logic [3:0]    be;
  logic [31:0]   wdata;
  logic          accept, timeout;

  // Decode of the incoming op; a store code overrides any load code.
  always_comb begin
    // NOTE: every variable written in a comb block gets a default first, so no path can infer a latch.
    is_store = (info_store != ST_NONE);
    is_load  = !is_store && (info_load inside {LD_B, LD_H, LD_W, LD_BU, LD_HU});
    rem      = alu_result[1:0];
    word_op  = (info_store == ST_W) || (is_load && info_load == LD_W);
    half_op  = (info_store == ST_H) || (is_load && (info_load == LD_H || info_load == LD_HU));
    mis      = (word_op && rem != 2'd0) || (half_op && rem == 2'd3);
    be       = 4'b0000;
    case (info_store)
      ST_B:    be = 4'b0001 << rem;
      ST_H:    be = 4'b0011 << rem;
      ST_W:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    wdata = is_store ? (store_data << {rem, 3'b000}) : 32'd0;
  end

  assign accept  = in_valid && in_ready;
  assign timeout = (state == BUS) && !mem_ack && (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = ((is_load || is_store) && !mis) ? BUS : RESP;
      BUS:  if (mem_ack || timeout) state_next = RESP;
      RESP: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // in_ready is also held low while reset is asserted so every output reads 0 in reset.
  always_comb begin
    in_ready  = (state == IDLE) && !rst;
    mem_req   = (state == BUS);
    out_valid = (state == RESP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt            <= '0;
      load_q         <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= 32'd0;
      mem_wdata      <= 32'd0;
      mem_be         <= 4'b0000;
      addr_data      <= 32'd0;
      addr_rem       <= 2'd0;
      info_load_out  <= 3'd0;
      alu_result_out <= 32'd0;
      misaligned     <= 1'b0;
      bus_err        <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          cnt            <= '0;
          load_q         <= is_load;
          mem_we         <= is_store;
          mem_addr       <= {alu_result[31:2], 2'b00};
          mem_wdata      <= wdata;
          mem_be         <= be;
          addr_data      <= 32'd0;
          addr_rem       <= rem;
          info_load_out  <= info_load;
          alu_result_out <= alu_result;
          misaligned     <= (is_load || is_store) && mis;
          bus_err        <= 1'b0;
        end
        BUS: begin
          if (mem_ack) begin
            addr_data <= load_q ? mem_rdata : 32'd0;
          end else if (timeout) begin
            addr_data <= 32'd0;
            bus_err   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: if (out_ready) begin
          misaligned <= 1'b0;
          bus_err    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed self-checking bench for mem_access with a short bus timeout.
module tb_mem_access;

  localparam logic [2:0] LD_H    = 3'b001;
  localparam logic [2:0] LD_W    = 3'b010;
  localparam logic [2:0] LD_NONE = 3'b111;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic [2:0]  info_load;
  logic [1:0]  info_store;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] addr_data;
  logic [1:0]  addr_rem;
  logic [2:0]  info_load_out;
  logic [31:0] alu_result_out;
  logic        misaligned;
  logic        bus_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_access #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .store_data(store_data),
    .info_load(info_load), .info_store(info_store),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .addr_data(addr_data), .addr_rem(addr_rem),
    .info_load_out(info_load_out), .alu_result_out(alu_result_out),
    .misaligned(misaligned), .bus_err(bus_err)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
      else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", tag, observed, expected);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one op for a single accepting cycle.
  task automatic issue(input logic [31:0] a, input logic [31:0] sd,
                       input logic [2:0] ld, input logic [1:0] st);
    alu_result = a; store_data = sd; info_load = ld; info_store = st;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic ack(input logic [31:0] rd);
    mem_ack = 1'b1; mem_rdata = rd;
    tick();
    mem_ack = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; alu_result = '0; store_data = '0;
    info_load = LD_NONE; info_store = 2'b00; mem_ack = 1'b0; mem_rdata = '0;
    out_ready = 1'b0;

    // Reset state
    #3;
    check("rst_in_ready",  in_ready,  0);
    check("rst_mem_req",   mem_req,   0);
    check("rst_out_valid", out_valid, 0);
    check("rst_addr_data", addr_data, 0);
    tick(); tick();
    rst = 1'b0;
    tick();
    check("idle_in_ready", in_ready, 1);

    // LW 0x100, acked in first BUS cycle
    issue(32'h100, 32'h0, LD_W, 2'b00);
    check("lw_mem_req",  mem_req,  1);
    check("lw_mem_addr", mem_addr, 32'h100);
    check("lw_mem_be",   mem_be,   4'b0000);
    check("lw_mem_we",   mem_we,   0);
    check("lw_in_ready", in_ready, 0);
    ack(32'hDEADBEEF);
    check("lw_req_drop",  mem_req,       0);
    check("lw_out_valid", out_valid,     1);
    check("lw_addr_data", addr_data,     32'hDEADBEEF);
    check("lw_rem",       addr_rem,      0);
    check("lw_info",      info_load_out, LD_W);
    check("lw_alu",       alu_result_out, 32'h100);
    drain();
    check("lw_done_valid", out_valid, 0);
    check("lw_done_ready", in_ready,  1);

    // SB at 0x203
    issue(32'h203, 32'h000000A5, LD_NONE, 2'b01);
    check("sb_mem_addr",  mem_addr,  32'h200);
    check("sb_mem_wdata", mem_wdata, 32'hA5000000);
    check("sb_mem_be",    mem_be,    4'b1000);
    check("sb_mem_we",    mem_we,    1);
    ack(32'h12345678);
    check("sb_out_valid", out_valid, 1);
    check("sb_addr_data", addr_data, 0);
    check("sb_rem",       addr_rem,  3);
    drain();

    // SH at 0x0F1 (rem 1 is legal for halves)
    issue(32'h0F1, 32'h0000BEEF, LD_NONE, 2'b10);
    check("sh_mem_req",   mem_req,   1);
    check("sh_mem_wdata", mem_wdata, 32'h00BEEF00);
    check("sh_mem_be",    mem_be,    4'b0110);
    ack(32'h0);
    drain();

    // Store wins over a simultaneous load code
    issue(32'h300, 32'h11223344, LD_W, 2'b11);
    check("sw_mem_be",    mem_be,    4'b1111);
    check("sw_mem_we",    mem_we,    1);
    check("sw_mem_wdata", mem_wdata, 32'h11223344);
    ack(32'h0000FFFF);
    check("sw_addr_data", addr_data, 0);
    drain();

    // Misaligned LH at 0x0F7
    issue(32'h0F7, 32'h0, LD_H, 2'b00);
    check("mlh_mem_req",    mem_req,    0);
    check("mlh_out_valid",  out_valid,  1);
    check("mlh_misaligned", misaligned, 1);
    check("mlh_rem",        addr_rem,   3);
    drain();
    check("mlh_mis_clear",  misaligned, 0);

    // Misaligned SW at 0x102
    issue(32'h102, 32'h55, LD_NONE, 2'b11);
    check("msw_mem_req",    mem_req,    0);
    check("msw_out_valid",  out_valid,  1);
    check("msw_misaligned", misaligned, 1);
    drain();

    // Non-memory op goes straight to RESP
    issue(32'hCAFEF00D, 32'h0, LD_NONE, 2'b00);
    check("alu_mem_req",    mem_req,        0);
    check("alu_out_valid",  out_valid,      1);
    check("alu_result",     alu_result_out, 32'hCAFEF00D);
    check("alu_misaligned", misaligned,     0);
    check("alu_addr_data",  addr_data,      0);
    drain();

    // Timeout: LW with no ack, then stall in RESP
    issue(32'h400, 32'h0, LD_W, 2'b00);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("to_req_%0d", i), mem_req, 1);
      check($sformatf("to_noerr_%0d", i), bus_err, 0);
      tick();
    end
    check("to_req_drop",  mem_req,   0);
    check("to_bus_err",   bus_err,   1);
    check("to_out_valid", out_valid, 1);
    check("to_addr_data", addr_data, 0);
    alu_result = 32'h999; info_load = LD_W; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("stall_valid_%0d", i), out_valid,      1);
      check($sformatf("stall_ready_%0d", i), in_ready,       0);
      check($sformatf("stall_err_%0d", i),   bus_err,        1);
      check($sformatf("stall_alu_%0d", i),   alu_result_out, 32'h400);
      check($sformatf("stall_req_%0d", i),   mem_req,        0);
    end
    in_valid = 1'b0;
    drain();
    check("to_err_clear", bus_err,        0);
    check("to_idle",      in_ready,       1);
    check("stall_no_acc", alu_result_out, 32'h400);

    // Reset mid-BUS, then stray ack
    issue(32'h500, 32'h0, LD_W, 2'b00);
    check("rb_mem_req", mem_req, 1);
    #2 rst = 1'b1;
    #1;
    check("rb_req_drop", mem_req,        0);
    check("rb_alu",      alu_result_out, 0);
    check("rb_mem_addr", mem_addr,       0);
    tick();
    rst = 1'b0;
    ack(32'hBAD0BAD0);
    check("rb_no_valid", out_valid, 0);
    check("rb_no_req",   mem_req,   0);
    check("rb_in_ready", in_ready,  1);
    check("rb_data",     addr_data, 0);
    tick();
    check("rb_still_idle", out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
